// File: rtl/sysbus_pkg.sv
// Shared constants and types for the Sysbus arbiter slice.
package sysbus_pkg;

   localparam int TAG_W  = 13;
   localparam int BEATS  = 8;
   localparam int CNT_W  = $clog2(BEATS);
   localparam int OP_BIT = TAG_W - 1;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [63:0]      LINE_MASK = ~64'h3F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic {
      REQ_F = 1'b0,
      REQ_M = 1'b1
   } req_id_t;

   // Align a byte address down to its 64-byte line.
   function automatic logic [63:0] line_addr(input logic [63:0] addr);
      return addr & LINE_MASK;
   endfunction

endpackage

// File: rtl/sysbus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_pick2
   import sysbus_pkg::*;
(
   input  logic    valid_f,
   input  logic    valid_m,
   input  req_id_t last_grant,
   output logic    any_valid,
   output req_id_t winner
);

   // Winner selection; winner is only meaningful while any_valid is high.
   always_comb begin
      any_valid = valid_f | valid_m;
      winner    = REQ_F;
      if (valid_f && valid_m)
         winner = (last_grant == REQ_F) ? REQ_M : REQ_F;
      else if (valid_m)
         winner = REQ_M;
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares one Sysbus master between fetch (F) and load/store (M): round-robin
// arbitration, request/ack handshake, write-beat sequencing for M and
// same-cycle routing of 8-beat read bursts back to the issuer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no transaction; arbitrate and latch the winner's request
//   ST_REQ   | bus_reqcyc held with line address/tag until bus_reqack
//   ST_WDATA | M write: stream BEATS write beats from m_wdata
//   ST_RESP  | read: forward BEATS response beats to the owner
module sysbus_arbiter
   import sysbus_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             f_req_valid,
   input  logic [63:0]      f_req_addr,
   input  logic [TAG_W-1:0] f_req_tag,
   output logic             f_req_ready,
   output logic             f_resp_valid,
   output logic [63:0]      f_resp_data,
   input  logic             m_req_valid,
   input  logic [63:0]      m_req_addr,
   input  logic [TAG_W-1:0] m_req_tag,
   output logic             m_req_ready,
   output logic             m_resp_valid,
   output logic [63:0]      m_resp_data,
   input  logic [63:0]      m_wdata,
   output logic             m_wdata_ready,
   output logic             bus_reqcyc,
   output logic [63:0]      bus_req,
   output logic [TAG_W-1:0] bus_reqtag,
   input  logic             bus_reqack,
   input  logic             bus_respcyc,
   input  logic [63:0]      bus_resp,
   input  logic [TAG_W-1:0] bus_resptag,
   output logic             bus_respack,
   output logic             err_stray
);

   if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_beats_check
      $error("sysbus_arbiter: BEATS must be a power of two >= 2");
   end

   state_t           state, state_nxt;
   req_id_t          owner, last_grant, winner;
   logic             any_valid;
   logic [63:0]      addr_q;
   logic [TAG_W-1:0] tag_q;
   logic [CNT_W-1:0] cnt;
   logic             is_write;
   logic             unused_f_op;

   // Fetch can never write, so its op bit is replaced rather than used.
   assign unused_f_op = f_req_tag[OP_BIT];
   assign is_write    = (tag_q[OP_BIT] == OP_WRITE);

   rr_pick2 u_pick (
      .valid_f    (f_req_valid),
      .valid_m    (m_req_valid),
      .last_grant (last_grant),
      .any_valid  (any_valid),
      .winner     (winner)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next state and all bus/requester outputs; outputs are decoded from state
   // so they fall to zero as soon as reset forces ST_IDLE.
   always_comb begin
      state_nxt     = state;
      bus_reqcyc    = 1'b0;
      bus_req       = '0;
      bus_reqtag    = '0;
      f_req_ready   = 1'b0;
      m_req_ready   = 1'b0;
      m_wdata_ready = 1'b0;
      f_resp_valid  = 1'b0;
      f_resp_data   = '0;
      m_resp_valid  = 1'b0;
      m_resp_data   = '0;
      bus_respack   = bus_respcyc & reset_n;
      case (state)
         ST_IDLE: begin
            if (any_valid) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            bus_reqcyc = 1'b1;
            bus_req    = addr_q;
            bus_reqtag = tag_q;
            if (bus_reqack) begin
               f_req_ready = (owner == REQ_F);
               m_req_ready = (owner == REQ_M);
               state_nxt   = is_write ? ST_WDATA : ST_RESP;
            end
         end
         ST_WDATA: begin
            bus_reqcyc    = 1'b1;
            bus_req       = m_wdata;
            bus_reqtag    = tag_q;
            m_wdata_ready = 1'b1;
            if (cnt == LAST_BEAT) state_nxt = ST_IDLE;
         end
         ST_RESP: begin
            if (owner == REQ_F) begin
               f_resp_valid = bus_respcyc;
               f_resp_data  = bus_respcyc ? bus_resp : '0;
            end else begin
               m_resp_valid = bus_respcyc;
               m_resp_data  = bus_respcyc ? bus_resp : '0;
            end
            if (bus_respcyc && cnt == LAST_BEAT) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request latch, grant history, beat counter and sticky stray-response flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner      <= REQ_F;
         last_grant <= REQ_M;
         addr_q     <= '0;
         tag_q      <= '0;
         cnt        <= '0;
         err_stray  <= 1'b0;
      end else begin
         if (state == ST_IDLE && any_valid) begin
            owner <= winner;
            if (winner == REQ_F) begin
               addr_q <= line_addr(f_req_addr);
               tag_q  <= {OP_READ, f_req_tag[OP_BIT-1:0]};
            end else begin
               addr_q <= line_addr(m_req_addr);
               tag_q  <= m_req_tag;
            end
         end
         if (state == ST_REQ && bus_reqack)
            last_grant <= owner;
         if (state == ST_WDATA || (state == ST_RESP && bus_respcyc))
            cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
         if (bus_respcyc && (state != ST_RESP || bus_resptag != tag_q))
            err_stray <= 1'b1;
      end
   end

   // The accepted requester must keep valid asserted until its ready pulse.
   a_hold_f: assert property (@(posedge clk) disable iff (!reset_n)
      (state == ST_REQ && owner == REQ_F) |-> f_req_valid);
   a_hold_m: assert property (@(posedge clk) disable iff (!reset_n)
      (state == ST_REQ && owner == REQ_M) |-> m_req_valid);

endmodule

// File: tb/tb_sysbus_arbiter.sv
module tb_sysbus_arbiter;
   import sysbus_pkg::*;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             f_req_valid, m_req_valid;
   logic [63:0]      f_req_addr, m_req_addr;
   logic [TAG_W-1:0] f_req_tag, m_req_tag;
   logic             f_req_ready, m_req_ready;
   logic             f_resp_valid, m_resp_valid;
   logic [63:0]      f_resp_data, m_resp_data;
   logic [63:0]      m_wdata;
   logic             m_wdata_ready;
   logic             bus_reqcyc;
   logic [63:0]      bus_req;
   logic [TAG_W-1:0] bus_reqtag;
   logic             bus_reqack, bus_respcyc;
   logic [63:0]      bus_resp;
   logic [TAG_W-1:0] bus_resptag;
   logic             bus_respack;
   logic             err_stray;

   int total  = 0;
   int passed = 0;
   int last_who;   // 0 = F, 1 = M; requester granted most recently

   always #5 clk = ~clk;

   sysbus_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_tag(f_req_tag),
      .f_req_ready(f_req_ready), .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
      .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_tag(m_req_tag),
      .m_req_ready(m_req_ready), .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
      .m_wdata(m_wdata), .m_wdata_ready(m_wdata_ready),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
      .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
      .bus_resptag(bus_resptag), .bus_respack(bus_respack), .err_stray(err_stray)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin rule: a lone requester wins; on a tie the one not served last.
   function automatic int pick(input bit fv, input bit mv);
      if (fv && mv) return (last_who == 1) ? 0 : 1;
      return fv ? 0 : 1;
   endfunction

   task automatic set_req(input int who, input bit v, input logic [63:0] a,
                          input logic [TAG_W-1:0] t);
      if (who == 0) begin f_req_valid = v; f_req_addr = a; f_req_tag = t; end
      else          begin m_req_valid = v; m_req_addr = a; m_req_tag = t; end
   endtask

   task automatic drop_req(input int who);
      if (who == 0) f_req_valid = 1'b0;
      else          m_req_valid = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n     = 1'b0;
      f_req_valid = 0; f_req_addr = 0; f_req_tag = 0;
      m_req_valid = 0; m_req_addr = 0; m_req_tag = 0;
      m_wdata = 0; bus_reqack = 0; bus_respcyc = 0; bus_resp = 0; bus_resptag = 0;
      tick();
      tick();
      reset_n  = 1'b1;
      last_who = 1;
   endtask

   // One full transaction as seen from the bus side. Call at the start of the
   // cycle in which the DUT is idle and the expected owner's valid is visible.
   task automatic run_txn(input int who, input logic [63:0] addr,
                          input logic [TAG_W-1:0] tag, input int ack_delay,
                          input logic [63:0] base, input bit keep,
                          input int bad_beat, input int abort_beat);
      logic [63:0]      exp_addr;
      logic [TAG_W-1:0] exp_tag;
      bit               is_wr;
      exp_addr = addr & ~64'h3F;
      exp_tag  = tag;
      if (who == 0) exp_tag[TAG_W-1] = 1'b0;
      is_wr = exp_tag[TAG_W-1];

      @(negedge clk);
      total++;
      if (bus_reqcyc !== 1'b0) $display("FAIL idle_gap: bus_reqcyc=%0b want 0", bus_reqcyc);
      else passed++;
      tick();

      for (int i = 0; i < ack_delay; i++) begin
         @(negedge clk);
         total++;
         if (bus_reqcyc !== 1'b1 || bus_req !== exp_addr || bus_reqtag !== exp_tag)
            $display("FAIL req_hold: cyc=%0b req=%h tag=%h want 1 %h %h",
                     bus_reqcyc, bus_req, bus_reqtag, exp_addr, exp_tag);
         else passed++;
         total++;
         if ({f_req_ready, m_req_ready} !== 2'b00)
            $display("FAIL early_ready: f=%0b m=%0b want 0 0", f_req_ready, m_req_ready);
         else passed++;
         tick();
      end

      bus_reqack = 1'b1;
      @(negedge clk);
      total++;
      if (bus_reqcyc !== 1'b1 || bus_req !== exp_addr || bus_reqtag !== exp_tag)
         $display("FAIL req_at_ack: cyc=%0b req=%h tag=%h want 1 %h %h",
                  bus_reqcyc, bus_req, bus_reqtag, exp_addr, exp_tag);
      else passed++;
      total++;
      if (f_req_ready !== (who == 0) || m_req_ready !== (who == 1))
         $display("FAIL grant: f_ready=%0b m_ready=%0b want owner %0d", f_req_ready, m_req_ready, who);
      else passed++;
      tick();
      bus_reqack = 1'b0;
      if (!keep) drop_req(who);
      last_who = who;
      if (is_wr) m_wdata = base;

      for (int b = 0; b < BEATS; b++) begin
         if (!is_wr) begin
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(b);
            bus_resptag = (b == bad_beat) ? (exp_tag ^ 1) : exp_tag;
         end
         if (b == abort_beat) begin
            reset_n = 1'b0;
            #1;
            total++;
            if ({bus_reqcyc, bus_req, bus_reqtag, f_req_ready, m_req_ready, f_resp_valid,
                 f_resp_data, m_resp_valid, m_resp_data, m_wdata_ready, bus_respack,
                 err_stray} !== '0)
               $display("FAIL async_reset: f_resp_valid=%0b respack=%0b reqcyc=%0b err=%0b want all 0",
                        f_resp_valid, bus_respack, bus_reqcyc, err_stray);
            else passed++;
            bus_respcyc = 1'b0;
            return;
         end
         @(negedge clk);
         if (b == 0) begin
            total++;
            if ({f_req_ready, m_req_ready} !== 2'b00)
               $display("FAIL ready_pulse_len: f=%0b m=%0b want 0 0", f_req_ready, m_req_ready);
            else passed++;
         end
         if (is_wr) begin
            total++;
            if (m_wdata_ready !== 1'b1 || bus_reqcyc !== 1'b1 || bus_req !== base + 64'(b))
               $display("FAIL wbeat%0d: wready=%0b cyc=%0b req=%h want 1 1 %h",
                        b, m_wdata_ready, bus_reqcyc, bus_req, base + 64'(b));
            else passed++;
            total++;
            if ({f_resp_valid, m_resp_valid} !== 2'b00)
               $display("FAIL wbeat_resp%0d: f=%0b m=%0b want 0 0", b, f_resp_valid, m_resp_valid);
            else passed++;
         end else begin
            total++;
            if (who == 0 ? (f_resp_valid !== 1'b1 || f_resp_data !== base + 64'(b) || m_resp_valid !== 1'b0)
                         : (m_resp_valid !== 1'b1 || m_resp_data !== base + 64'(b) || f_resp_valid !== 1'b0))
               $display("FAIL rbeat%0d: f=%0b/%h m=%0b/%h want owner %0d data %h",
                        b, f_resp_valid, f_resp_data, m_resp_valid, m_resp_data, who, base + 64'(b));
            else passed++;
            total++;
            if (bus_respack !== 1'b1 || bus_reqcyc !== 1'b0)
               $display("FAIL rbeat_bus%0d: respack=%0b reqcyc=%0b want 1 0", b, bus_respack, bus_reqcyc);
            else passed++;
         end
         tick();
         if (is_wr) m_wdata = base + 64'(b + 1);
      end
      bus_respcyc = 1'b0;
      m_wdata     = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      f_req_valid = 1; m_req_valid = 1; bus_respcyc = 0; bus_reqack = 0;
      f_req_addr = 64'h40; m_req_addr = 64'h80; f_req_tag = 1; m_req_tag = 2;
      m_wdata = 0; bus_resp = 0; bus_resptag = 0;
      tick();
      @(negedge clk);
      total++;
      if ({bus_reqcyc, bus_req, bus_reqtag, f_req_ready, m_req_ready, f_resp_valid,
           m_resp_valid, m_wdata_ready, bus_respack, err_stray} !== '0)
         $display("FAIL reset_outputs: reqcyc=%0b req=%h err=%0b want all 0", bus_reqcyc, bus_req, err_stray);
      else passed++;
      apply_reset();
   endtask

   task automatic test_f_read();
      set_req(0, 1, 64'h1000, 13'h0005);
      run_txn(0, 64'h1000, 13'h0005, 2, 64'hA0, 0, -1, -1);
      @(negedge clk);
      total++;
      if (err_stray !== 1'b0) $display("FAIL f_read_err: err_stray=%0b want 0", err_stray);
      else passed++;
      tick();
   endtask

   task automatic test_alternation();
      apply_reset();
      set_req(0, 1, 64'h1000, 13'h0011);
      set_req(1, 1, 64'h2040, 13'h0022);
      for (int k = 0; k < 4; k++) begin
         int w;
         w = pick(1, 1);
         total++;
         if (w !== (k % 2)) $display("FAIL alt_model%0d: model pick=%0d want %0d", k, w, k % 2);
         else passed++;
         run_txn(w, w == 0 ? 64'h1000 : 64'h2040, w == 0 ? 13'h0011 : 13'h0022,
                 1, 64'h300 + 64'(k * 16), 1, -1, -1);
      end
      drop_req(0);
      drop_req(1);
      tick();
   endtask

   task automatic test_m_write();
      set_req(1, 1, 64'h2040, 13'h1003);
      run_txn(1, 64'h2040, 13'h1003, 1, 64'h10, 0, -1, -1);
      @(negedge clk);
      total++;
      if (bus_reqcyc !== 1'b0 || m_wdata_ready !== 1'b0)
         $display("FAIL write_end: reqcyc=%0b wready=%0b want 0 0", bus_reqcyc, m_wdata_ready);
      else passed++;
      tick();
   endtask

   task automatic test_ack_stall();
      set_req(0, 1, 64'h7FC3, 13'h1ABC);
      run_txn(0, 64'h7FC3, 13'h1ABC, 20, 64'hBEEF00, 0, -1, -1);
   endtask

   task automatic test_random();
      bit               pend[2];
      logic [63:0]      paddr[2];
      logic [TAG_W-1:0] ptag[2];
      pend[0] = 0; pend[1] = 0;
      for (int it = 0; it < 16; it++) begin
         int w;
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 1) == 1) begin
               pend[p]  = 1;
               paddr[p] = {$urandom, $urandom};
               ptag[p]  = TAG_W'($urandom);
               set_req(p, 1, paddr[p], ptag[p]);
            end
         end
         if (!pend[0] && !pend[1]) begin
            pend[0] = 1; paddr[0] = {$urandom, $urandom}; ptag[0] = TAG_W'($urandom);
            set_req(0, 1, paddr[0], ptag[0]);
         end
         w = pick(pend[0], pend[1]);
         run_txn(w, paddr[w], ptag[w], $urandom_range(0, 3), {$urandom, $urandom}, 0, -1, -1);
         pend[w] = 0;
      end
      for (int p = 0; p < 2; p++) begin
         if (pend[p]) begin
            run_txn(p, paddr[p], ptag[p], 0, 64'h5A5A0000, 0, -1, -1);
            pend[p] = 0;
         end
      end
      @(negedge clk);
      total++;
      if (err_stray !== 1'b0) $display("FAIL random_err: err_stray=%0b want 0", err_stray);
      else passed++;
      tick();
   endtask

   task automatic test_tag_mismatch();
      apply_reset();
      set_req(0, 1, 64'h3000, 13'h0044);
      run_txn(0, 64'h3000, 13'h0044, 0, 64'hC0, 0, 3, -1);
      @(negedge clk);
      total++;
      if (err_stray !== 1'b1) $display("FAIL tag_mismatch_err: err_stray=%0b want 1", err_stray);
      else passed++;
      tick();
      set_req(1, 1, 64'h3100, 13'h0055);
      run_txn(1, 64'h3100, 13'h0055, 0, 64'hD0, 0, -1, -1);
      @(negedge clk);
      total++;
      if (err_stray !== 1'b1) $display("FAIL err_sticky: err_stray=%0b want 1", err_stray);
      else passed++;
      apply_reset();
      @(negedge clk);
      total++;
      if (err_stray !== 1'b0) $display("FAIL err_cleared: err_stray=%0b want 0", err_stray);
      else passed++;
      tick();
   endtask

   task automatic test_idle_stray();
      bus_respcyc = 1'b1;
      bus_resp    = 64'hDEAD;
      bus_resptag = 13'h0001;
      @(negedge clk);
      total++;
      if (bus_respack !== 1'b1 || f_resp_valid !== 1'b0 || m_resp_valid !== 1'b0 || err_stray !== 1'b0)
         $display("FAIL idle_stray_beat: respack=%0b f=%0b m=%0b err=%0b want 1 0 0 0",
                  bus_respack, f_resp_valid, m_resp_valid, err_stray);
      else passed++;
      tick();
      bus_respcyc = 1'b0;
      @(negedge clk);
      total++;
      if (err_stray !== 1'b1) $display("FAIL idle_stray_err: err_stray=%0b want 1", err_stray);
      else passed++;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      set_req(0, 1, 64'h4000, 13'h0066);
      run_txn(0, 64'h4000, 13'h0066, 0, 64'hE0, 0, -1, 4);
      tick();
      tick();
      reset_n  = 1'b1;
      last_who = 1;
      set_req(0, 1, 64'h4040, 13'h0077);
      run_txn(0, 64'h4040, 13'h0077, 1, 64'hF0, 0, -1, -1);
      @(negedge clk);
      total++;
      if (err_stray !== 1'b0 || bus_reqcyc !== 1'b0)
         $display("FAIL after_abort: err=%0b reqcyc=%0b want 0 0", err_stray, bus_reqcyc);
      else passed++;
      tick();
   endtask

   initial begin
      test_reset();
      test_f_read();
      test_alternation();
      test_m_write();
      test_ack_stall();
      test_random();
      test_tag_mismatch();
      test_idle_stray();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
